// File: rtl/cr_huf_comp_htb_short_merge.sv
// In-order reader/merger for the two short-tree-builder pipes: grants the pipe holding the
// next expected seq_id, reads its depths and streams them out. Optional: CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN.
module cr_huf_comp_htb_short_merge #(
    parameter int SEQID_W = 4,
    parameter int DPTH_W  = 5,
    parameter int NUM_RD  = 16,
    parameter int ADDR_W  = 4,
    parameter int RD_LAT  = 1
`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ht1_done,
    input  logic [SEQID_W-1:0]    ht1_seq_id,
    input  logic                  ht1_build_error,
    input  logic [2*DPTH_W-1:0]   ht1_rd_data,
    output logic                  ht1_sym_freq_rd,
    output logic [ADDR_W-1:0]     ht1_sym_freq_addr,
    output logic                  ht1_rd_done,
    input  logic                  ht2_done,
    input  logic [SEQID_W-1:0]    ht2_seq_id,
    input  logic                  ht2_build_error,
    input  logic [2*DPTH_W-1:0]   ht2_rd_data,
    output logic                  ht2_sym_freq_rd,
    output logic [ADDR_W-1:0]     ht2_sym_freq_addr,
    output logic                  ht2_rd_done,
    input  logic                  sw_disable_second_pipe,
    input  logic                  hw_not_ready,
    output logic                  hw_valid,
    output logic [2*DPTH_W-1:0]   hw_data,
    output logic                  hw_sop,
    output logic                  hw_eop,
    output logic [SEQID_W-1:0]    hw_seq_id,
    output logic                  hw_pipe_sel,
    output logic                  hw_build_error,
    output logic                  seq_err
`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_ERR, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [SEQID_W-1:0]    exp_seq_q, exp_seq_d;
    logic [SEQID_W-1:0]    seq_q, seq_d;
    logic [ADDR_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  sel_q, sel_d;
    logic                  berr_q, berr_d;
    logic [2*DPTH_W-1:0]   data_q, data_d;

    logic match1, match2, grant, grant_berr, beat_st, accept, last_rd, wait_last;

    // Pipe 1 wins ties; pipe 2 only competes while enabled.
    assign match1     = ht1_done && (ht1_seq_id == exp_seq_q);
    assign match2     = ht2_done && !sw_disable_second_pipe && (ht2_seq_id == exp_seq_q);
    assign grant      = (state_q == S_IDLE) && (match1 || match2);
    assign grant_berr = match1 ? ht1_build_error : ht2_build_error;
    assign beat_st    = (state_q == S_OUT) || (state_q == S_ERR);
    assign accept     = beat_st && !hw_not_ready;
    assign last_rd    = (rd_cnt_q == ADDR_W'(NUM_RD - 1));
    assign wait_last  = (wait_cnt_q == 2'(RD_LAT - 1));

`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
    localparam int TMO_W = 10;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            exp_seq_q  <= '0;
            seq_q      <= '0;
            rd_cnt_q   <= '0;
            wait_cnt_q <= '0;
            sel_q      <= 1'b0;
            berr_q     <= 1'b0;
            data_q     <= '0;
`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            exp_seq_q  <= exp_seq_d;
            seq_q      <= seq_d;
            rd_cnt_q   <= rd_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            sel_q      <= sel_d;
            berr_q     <= berr_d;
            data_q     <= data_d;
`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_err_q  <= tmo_err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant) state_d = grant_berr ? S_ERR : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = S_OUT;
            S_OUT:   if (accept) state_d = last_rd ? S_DONE : S_ISSUE;
            S_ERR:   if (accept) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        exp_seq_d  = exp_seq_q;
        seq_d      = seq_q;
        rd_cnt_d   = rd_cnt_q;
        wait_cnt_d = wait_cnt_q;
        sel_d      = sel_q;
        berr_d     = berr_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: if (grant) begin
                sel_d    = !match1;
                seq_d    = exp_seq_q;
                berr_d   = grant_berr;
                rd_cnt_d = '0;
            end
            S_ISSUE: wait_cnt_d = '0;
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 2'd1;
                if (wait_last) data_d = sel_q ? ht2_rd_data : ht1_rd_data;
            end
            S_OUT: if (accept && !last_rd) rd_cnt_d = rd_cnt_q + ADDR_W'(1);
            S_DONE: begin
                exp_seq_d = exp_seq_q + SEQID_W'(1);
                rd_cnt_d  = '0;
            end
            default: ;
        endcase
`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        // A stalled IDLE with a pending result eventually gives up on the missing id.
        if (grant) begin
            tmo_cnt_d = '0;
        end else if ((state_q == S_IDLE) && (ht1_done || ht2_done)) begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                tmo_err_d = 1'b1;
                exp_seq_d = exp_seq_q + SEQID_W'(1);
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif
    end

    always_comb begin
        ht1_sym_freq_rd   = 1'b0;
        ht1_sym_freq_addr = '0;
        ht2_sym_freq_rd   = 1'b0;
        ht2_sym_freq_addr = '0;
        ht1_rd_done       = 1'b0;
        ht2_rd_done       = 1'b0;
        hw_valid          = beat_st;
        hw_data           = '0;
        hw_sop            = 1'b0;
        hw_eop            = 1'b0;
        hw_seq_id         = '0;
        hw_pipe_sel       = 1'b0;
        hw_build_error    = 1'b0;
        seq_err           = (state_q == S_IDLE) && match1 && match2;
        if (state_q == S_ISSUE) begin
            if (sel_q) begin
                ht2_sym_freq_rd   = 1'b1;
                ht2_sym_freq_addr = rd_cnt_q;
            end else begin
                ht1_sym_freq_rd   = 1'b1;
                ht1_sym_freq_addr = rd_cnt_q;
            end
        end
        if (state_q == S_DONE) begin
            ht1_rd_done = !sel_q;
            ht2_rd_done = sel_q;
        end
        if (beat_st) begin
            hw_seq_id   = seq_q;
            hw_pipe_sel = sel_q;
        end
        if (state_q == S_OUT) begin
            hw_data = data_q;
            hw_sop  = (rd_cnt_q == '0);
            hw_eop  = last_rd;
        end
        if (state_q == S_ERR) begin
            hw_sop         = 1'b1;
            hw_eop         = 1'b1;
            hw_build_error = 1'b1;
        end
    end

`ifdef CR_HUF_COMP_HTB_MERGE_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`endif

endmodule
